spike_generator: RTL and testbench
==================================

// Module: spike_generator
// PURPOSE
//  Downstream of the potential decay/adder stage for one neuron. Each timestep it takes the
//  updated IEEE-754 single membrane potential and compares it with the firing threshold.
//  On firing it resets the potential and queues a spike packet {neuron address, timestep}
//  for the network interface. The post-fire potential is returned to the decay stage.
// PARAMETERS
//  ADDR_W   12  neuron address width
//  TS_W     8   timestep counter width in spike packets
//  REF_W    4   refractory counter width (used only with SPIKE_GEN_REFRACTORY_EN)
//  FIFO_D   2   spike packet buffer depth (power of 2, >=2)
// PORTS
//  CLK                            in   1           single clock, all logic on posedge
//  clear_n                        in   1           synchronous active-low reset
//  neuron_address_initialization  in   ADDR_W      own address, sampled while clear_n=0
//  cfg_we                         in   1           load threshold/v_reset/ref_period
//  cfg_threshold                  in   32          firing threshold (float32)
//  cfg_v_reset                    in   32          post-fire potential (float32)
//  cfg_ref_period                 in   REF_W       refractory timesteps
//  timestep                       in   TS_W        current timestep number
//  potential_valid                in   1           1-cycle strobe, one per timestep
//  potential_in                   in   32          new_potential from adder (float32)
//  potential_out                  out  32          potential fed back to decay stage
//  potential_out_valid            out  1           1-cycle strobe
//  spike_valid / spike_ready      out/in 1         packet handshake to network interface
//  spike_packet                   out  ADDR_W+TS_W {address, timestep}
//  spike_dropped                  out  1           sticky, buffer overflow seen
// BEHAVIOUR
//  - Reset (clear_n=0 at posedge): all outputs 0, FIFO empty, refractory count 0, threshold=
//    32'h7F800000 (+inf, never fires), v_reset=0, address latched from init port.
//  - cfg_we at posedge loads config regs. Concurrent potential_valid uses the OLD config.
//  - Float compare, fire iff potential_in >= threshold. Sign-magnitude ordering. -0 == +0.
//    NaN on either operand never fires. Denormals compare by raw bits.
//  - Latency: potential_valid at edge N gives potential_out_valid at N+1.
//    potential_out = v_reset if fired, else potential_in unchanged.
//  - Fire enqueues the packet at N+1. spike_valid rises at N+1 if the FIFO was empty.
//  - Handshake: the packet transfers on posedge with spike_valid & spike_ready.
//    spike_packet stays stable while valid & !ready.
//  - FIFO full on fire: the packet is dropped and spike_dropped is set (sticky until reset).
//    The potential is still reset to v_reset.
//  - FIFO full with a simultaneous pop and fire: the pop is counted first, so there is no drop.
//  - FSM: READY -> (fire & ref_period!=0) -> REFRACTORY. REFRACTORY decrements on each
//    potential_valid and returns to READY when the count hits 0. In REFRACTORY there is no
//    fire and potential_out = v_reset.
//  - Reset mid-operation: queued packets are discarded and the FSM returns to READY.
// CONFIGURATION
//  SPIKE_GEN_REFRACTORY_EN defined: refractory counter and REFRACTORY state are present.
//  Not defined: FSM fixed in READY, cfg_ref_period ignored, the neuron may fire every timestep.
// STRUCTURE
//  snn_pkg (shared header): FP32_POS_INF, FP32_ZERO, packet field widths/offsets, FSM encodings.
//  Sub-module spike_fifo: synchronous FIFO_D-deep, push/pop/full/empty, simultaneous push+pop
//  on full allowed.
// TESTING
//  1 thr=0x41200000(10.0), in=0x41300000(11.0), addr 5, ts 3 -> out=v_reset, packet {5,3} at N+1
//  2 in=0xC1300000(-11), thr=0xC1200000(-10) -> no fire, out=0xC1300000
//  3 in=0x7FC00000 NaN; in=0x80000000 vs thr 0 -> NaN no fire; -0 fires (equal)
//  4 spike_ready=0, 3 fires -> 2 queued, 3rd dropped, spike_dropped=1, packet held stable
//  5 REFRACTORY_EN, ref_period=2, in always > thr -> fires ts 0,3,6; defined-out: every ts
//  6 clear_n=0 with 2 queued -> spike_valid=0 next cycle, threshold=+inf, no fire after

Source files
------------

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//  Shared definitions for the spiking-neuron datapath: float32 constants,
//  default field widths for spike packets and the refractory counter, the
//  spike generator FSM encoding, and a float32 ">=" comparator.
//  No ports (package).
// ---------------------------------------------------------------------------
package snn_pkg;

  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

  // Default widths; the spike packet is {address, timestep}, timestep in the LSBs.
  localparam int SNN_ADDR_W     = 12;
  localparam int SNN_TS_W       = 8;
  localparam int SNN_REF_W      = 4;
  localparam int SNN_FIFO_D     = 2;
  localparam int SNN_PKT_TS_LSB = 0;

  typedef enum logic {
    SG_READY      = 1'b0,
    SG_REFRACTORY = 1'b1
  } sg_state_e;

  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // a >= b under IEEE ordering: NaN on either side is false, -0 equals +0.
  // Magnitudes (including denormals) order correctly as raw unsigned bits.
  function automatic logic fp32_ge(input logic [31:0] a, input logic [31:0] b);
    logic res;
    if (fp32_is_nan(a) || fp32_is_nan(b)) begin
      res = 1'b0;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      res = 1'b1;
    end else begin
      case ({a[31], b[31]})
        2'b00:   res = (a[30:0] >= b[30:0]);
        2'b01:   res = 1'b1;
        2'b10:   res = 1'b0;
        default: res = (a[30:0] <= b[30:0]);
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// ---------------------------------------------------------------------------
// spike_fifo
//  Synchronous D-deep FIFO for spike packets (D a power of two, >= 2).
//  A push while full is accepted when a pop happens in the same cycle.
//  Ports:
//   CLK        clock, posedge
//   clear_n    synchronous active-low reset (empties the FIFO)
//   push       write push_data (ignored when full and no pop)
//   pop        remove head entry (ignored when empty)
//   push_data  entry to write
//   pop_data   head entry, valid while !empty
//   full/empty occupancy flags
// ---------------------------------------------------------------------------
module spike_fifo #(
  parameter int W = 20,
  parameter int D = 2
) (
  input  logic         CLK,
  input  logic         clear_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(D));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spike_generator.sv
// ---------------------------------------------------------------------------
// spike_generator
//  Per-neuron threshold stage. Each potential_valid strobe compares the new
//  float32 potential with the threshold; on a fire the potential is replaced
//  by v_reset and a {address, timestep} packet is queued for the network.
//  Optional macro: SPIKE_GEN_REFRACTORY_EN adds a refractory period after
//  each fire (counted in potential_valid strobes).
//  Ports:
//   CLK, clear_n                   clock / synchronous active-low reset
//   neuron_address_initialization  own address, latched while clear_n=0
//   cfg_we, cfg_threshold, cfg_v_reset, cfg_ref_period  configuration load
//   timestep                       timestep stamped into spike packets
//   potential_valid, potential_in  new potential strobe and value
//   potential_out(_valid)          post-fire potential, one cycle later
//   spike_valid/ready/packet       packet stream to the network interface
//   spike_dropped                  sticky: a packet was lost to a full buffer
//   debug_state                    current FSM state
//  Handshake: a packet transfers on a posedge where spike_valid & spike_ready;
//  while valid & !ready, spike_packet holds its value.
// ---------------------------------------------------------------------------
module spike_generator
  import snn_pkg::*;
#(
  parameter int ADDR_W = SNN_ADDR_W,
  parameter int TS_W   = SNN_TS_W,
  parameter int REF_W  = SNN_REF_W,
  parameter int FIFO_D = SNN_FIFO_D
) (
  input  logic                   CLK,
  input  logic                   clear_n,
  input  logic [ADDR_W-1:0]      neuron_address_initialization,
  input  logic                   cfg_we,
  input  logic [31:0]            cfg_threshold,
  input  logic [31:0]            cfg_v_reset,
  input  logic [REF_W-1:0]       cfg_ref_period,
  input  logic [TS_W-1:0]        timestep,
  input  logic                   potential_valid,
  input  logic [31:0]            potential_in,
  output logic [31:0]            potential_out,
  output logic                   potential_out_valid,
  output logic                   spike_valid,
  input  logic                   spike_ready,
  output logic [ADDR_W+TS_W-1:0] spike_packet,
  output logic                   spike_dropped,
  output sg_state_e              debug_state
);

  localparam int PKT_W = ADDR_W + TS_W;

  logic [ADDR_W-1:0] address;
  logic [31:0]       threshold;
  logic [31:0]       v_reset;
  sg_state_e         state;
  logic              in_refractory;
  logic              fire;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PKT_W-1:0]  packet;

  assign in_refractory = (state == SG_REFRACTORY);
  // Compare uses the registered threshold, so a same-cycle cfg_we has no effect yet.
  assign fire          = potential_valid & ~in_refractory & fp32_ge(potential_in, threshold);
  assign pop           = spike_valid & spike_ready;
  // A pop in the same cycle frees a slot, so a full buffer only drops without one.
  assign drop          = fire & fifo_full & ~pop;
  assign packet        = {address, timestep};
  assign spike_valid   = ~fifo_empty;
  assign debug_state   = state;

`ifdef SPIKE_GEN_REFRACTORY_EN
  logic [REF_W-1:0] ref_period;
  logic [REF_W-1:0] ref_cnt;

  always_ff @(posedge CLK) begin
    if (!clear_n) begin
      state      <= SG_READY;
      ref_period <= '0;
      ref_cnt    <= '0;
    end else begin
      if (cfg_we) ref_period <= cfg_ref_period;
      case (state)
        SG_READY: begin
          if (fire && (ref_period != '0)) begin
            state   <= SG_REFRACTORY;
            ref_cnt <= ref_period;
          end
        end
        SG_REFRACTORY: begin
          // Each suppressed timestep consumes one count; leave after the last.
          if (potential_valid) begin
            ref_cnt <= ref_cnt - REF_W'(1);
            if (ref_cnt == REF_W'(1)) state <= SG_READY;
          end
        end
        default: state <= SG_READY;
      endcase
    end
  end
`else
  logic unused_ref_period;

  assign state             = SG_READY;
  assign unused_ref_period = ^cfg_ref_period;
`endif

  always_ff @(posedge CLK) begin
    if (!clear_n) begin
      address             <= neuron_address_initialization;
      threshold           <= FP32_POS_INF;
      v_reset             <= FP32_ZERO;
      potential_out       <= '0;
      potential_out_valid <= 1'b0;
      spike_dropped       <= 1'b0;
    end else begin
      if (cfg_we) begin
        threshold <= cfg_threshold;
        v_reset   <= cfg_v_reset;
      end
      potential_out_valid <= potential_valid;
      if (potential_valid) begin
        potential_out <= (fire || in_refractory) ? v_reset : potential_in;
      end
      if (drop) spike_dropped <= 1'b1;
    end
  end

  spike_fifo #(
    .W (PKT_W),
    .D (FIFO_D)
  ) u_fifo (
    .CLK       (CLK),
    .clear_n   (clear_n),
    .push      (fire),
    .pop       (pop),
    .push_data (packet),
    .pop_data  (spike_packet),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spike_generator.sv
// ---------------------------------------------------------------------------
// tb_spike_generator
//  Directed scenarios plus a randomized run for spike_generator. Expected
//  values come from a reference model that evaluates the float compare with
//  real arithmetic and keeps the packet buffer as a queue.
// ---------------------------------------------------------------------------
module tb_spike_generator;

  localparam int ADDR_W = 12;
  localparam int TS_W   = 8;
  localparam int REF_W  = 4;
  localparam int FIFO_D = 2;
  localparam int PKT_W  = ADDR_W + TS_W;

  // ---------------- clock / reset / DUT ----------------
  logic              CLK = 1'b0;
  logic              clear_n;
  logic [ADDR_W-1:0] neuron_address_initialization;
  logic              cfg_we;
  logic [31:0]       cfg_threshold;
  logic [31:0]       cfg_v_reset;
  logic [REF_W-1:0]  cfg_ref_period;
  logic [TS_W-1:0]   timestep;
  logic              potential_valid;
  logic [31:0]       potential_in;
  logic [31:0]       potential_out;
  logic              potential_out_valid;
  logic              spike_valid;
  logic              spike_ready;
  logic [PKT_W-1:0]  spike_packet;
  logic              spike_dropped;
  logic              debug_state;

  always #5 CLK = ~CLK;

  spike_generator #(
    .ADDR_W (ADDR_W),
    .TS_W   (TS_W),
    .REF_W  (REF_W),
    .FIFO_D (FIFO_D)
  ) dut (
    .CLK                           (CLK),
    .clear_n                       (clear_n),
    .neuron_address_initialization (neuron_address_initialization),
    .cfg_we                        (cfg_we),
    .cfg_threshold                 (cfg_threshold),
    .cfg_v_reset                   (cfg_v_reset),
    .cfg_ref_period                (cfg_ref_period),
    .timestep                      (timestep),
    .potential_valid               (potential_valid),
    .potential_in                  (potential_in),
    .potential_out                 (potential_out),
    .potential_out_valid           (potential_out_valid),
    .spike_valid                   (spike_valid),
    .spike_ready                   (spike_ready),
    .spike_packet                  (spike_packet),
    .spike_dropped                 (spike_dropped),
    .debug_state                   (debug_state)
  );

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [PKT_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_thr;
  logic [31:0]       m_vr;
  int                m_ref;
  int                m_block;
  logic              m_dropped;
  logic [31:0]       m_pout;
  logic              m_pv;

  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  // Numeric value of a non-NaN float32; infinities map to +/-1e300.
  function automatic real fval(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'hFF) begin
      m = 1.0e300;
    end else begin
      if (b[30:23] == 8'd0) begin
        m = real'(b[22:0]);
        e = -149;
      end else begin
        m = real'({1'b1, b[22:0]});
        e = int'(b[30:23]) - 150;
      end
      m = m * (2.0 ** e);
    end
    return b[31] ? -m : m;
  endfunction

  function automatic bit fires(input logic [31:0] v, input logic [31:0] t);
    if (is_nan(v) || is_nan(t)) return 1'b0;
    return fval(v) >= fval(t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_clear(input logic [ADDR_W-1:0] addr);
    clear_n                       = 1'b0;
    neuron_address_initialization = addr;
    cfg_we                        = 1'b0;
    potential_valid               = 1'b0;
    @(posedge CLK); #1;
    clear_n   = 1'b1;
    m_addr    = addr;
    m_thr     = 32'h7F80_0000;
    m_vr      = 32'h0;
    m_ref     = 0;
    m_block   = 0;
    m_dropped = 1'b0;
    m_pout    = 32'h0;
    m_pv      = 1'b0;
    exp_q.delete();
  endtask

  // Applies one clock of stimulus and advances the model accordingly.
  task automatic drive(input logic we, input logic [31:0] thr, input logic [31:0] vr,
                       input logic [REF_W-1:0] rp, input logic pv, input logic [31:0] pin,
                       input logic [TS_W-1:0] ts, input logic rdy);
    bit blocked;
    bit f;
    cfg_we          = we;
    cfg_threshold   = thr;
    cfg_v_reset     = vr;
    cfg_ref_period  = rp;
    potential_valid = pv;
    potential_in    = pin;
    timestep        = ts;
    spike_ready     = rdy;
    blocked = (m_block != 0);
    f       = pv && !blocked && fires(pin, m_thr);
    if (pv) begin
      m_pout = (f || blocked) ? m_vr : pin;
`ifdef SPIKE_GEN_REFRACTORY_EN
      if (blocked) m_block = m_block - 1;
      else if (f)  m_block = m_ref;
`endif
    end
    m_pv = pv;
    if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (f) begin
      if (exp_q.size() < FIFO_D) exp_q.push_back({m_addr, ts});
      else m_dropped = 1'b1;
    end
    if (we) begin
      m_thr = thr;
      m_vr  = vr;
      m_ref = int'(rp);
    end
    @(posedge CLK); #1;
    cfg_we          = 1'b0;
    potential_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] thr, input logic [31:0] vr, input logic [REF_W-1:0] rp);
    drive(1'b1, thr, vr, rp, 1'b0, 32'h0, 8'd0, spike_ready);
  endtask

  task automatic fire_at(input logic [31:0] pin, input logic [TS_W-1:0] ts, input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b1, pin, ts, rdy);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_clear(12'd5);
    n_vec++; if (potential_out !== 32'h0) begin n_err++; $display("FAIL reset_pout got %h exp %h", potential_out, 32'h0); end
    n_vec++; if (potential_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_pout_valid got %b exp 0", potential_out_valid); end
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL reset_spike_valid got %b exp 0", spike_valid); end
    n_vec++; if (spike_dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped got %b exp 0", spike_dropped); end
    // Threshold is +inf after reset, so a large finite input must pass through.
    spike_ready = 1'b0;
    fire_at(32'h7F00_0000, 8'd1, 1'b0);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_fire got %b exp 0", spike_valid); end
    n_vec++; if (potential_out !== 32'h7F00_0000) begin n_err++; $display("FAIL reset_pass got %h exp %h", potential_out, 32'h7F00_0000); end
  endtask

  task automatic test_fire_basic();
    do_clear(12'd5);
    spike_ready = 1'b0;
    load_cfg(32'h4120_0000, 32'h3F80_0000, 4'd0);
    fire_at(32'h4130_0000, 8'd3, 1'b0);
    n_vec++; if (potential_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_pout_valid got %b exp 1", potential_out_valid); end
    n_vec++; if (potential_out !== 32'h3F80_0000) begin n_err++; $display("FAIL basic_pout got %h exp %h", potential_out, 32'h3F80_0000); end
    n_vec++; if (spike_valid !== 1'b1) begin n_err++; $display("FAIL basic_spike_valid got %b exp 1", spike_valid); end
    n_vec++; if (spike_packet !== {12'd5, 8'd3}) begin n_err++; $display("FAIL basic_packet got %h exp %h", spike_packet, {12'd5, 8'd3}); end
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 8'd0, 1'b1);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL basic_popped got %b exp 0", spike_valid); end
    n_vec++; if (potential_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_strobe got %b exp 0", potential_out_valid); end
  endtask

  task automatic test_compare_edges();
    do_clear(12'd5);
    spike_ready = 1'b1;
    load_cfg(32'hC120_0000, 32'h3F80_0000, 4'd0);
    fire_at(32'hC130_0000, 8'd4, 1'b1);
    n_vec++; if (potential_out !== 32'hC130_0000) begin n_err++; $display("FAIL neg_pout got %h exp %h", potential_out, 32'hC130_0000); end
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL neg_no_fire got %b exp 0", spike_valid); end
    fire_at(32'h7FC0_0000, 8'd5, 1'b1);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL nan_in got %b exp 0", spike_valid); end
    n_vec++; if (potential_out !== 32'h7FC0_0000) begin n_err++; $display("FAIL nan_pout got %h exp %h", potential_out, 32'h7FC0_0000); end
    load_cfg(32'h0000_0000, 32'h3F80_0000, 4'd0);
    fire_at(32'h8000_0000, 8'd6, 1'b1);
    n_vec++; if (spike_valid !== 1'b1) begin n_err++; $display("FAIL negzero_fire got %b exp 1", spike_valid); end
    n_vec++; if (potential_out !== 32'h3F80_0000) begin n_err++; $display("FAIL negzero_pout got %h exp %h", potential_out, 32'h3F80_0000); end
    // Smallest negative denormal is below +0: no fire.
    fire_at(32'h8000_0001, 8'd7, 1'b1);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL denorm_neg got %b exp 0", spike_valid); end
    load_cfg(32'h7FC0_0000, 32'h3F80_0000, 4'd0);
    fire_at(32'h4130_0000, 8'd8, 1'b1);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL nan_thr got %b exp 0", spike_valid); end
    // New config in the same cycle as a valid potential: old threshold (NaN) applies.
    drive(1'b1, 32'h0, 32'h3F80_0000, 4'd0, 1'b1, 32'h4130_0000, 8'd9, 1'b1);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL old_cfg got %b exp 0", spike_valid); end
  endtask

  task automatic test_overflow();
    do_clear(12'd5);
    spike_ready = 1'b0;
    load_cfg(32'h0, 32'h4000_0000, 4'd0);
    for (int i = 0; i < 3; i++) fire_at(32'h3F80_0000, 8'(10 + i), 1'b0);
    n_vec++; if (spike_dropped !== 1'b1) begin n_err++; $display("FAIL ovf_dropped got %b exp 1", spike_dropped); end
    n_vec++; if (spike_packet !== {12'd5, 8'd10}) begin n_err++; $display("FAIL ovf_held got %h exp %h", spike_packet, {12'd5, 8'd10}); end
    n_vec++; if (potential_out !== 32'h4000_0000) begin n_err++; $display("FAIL ovf_pout got %h exp %h", potential_out, 32'h4000_0000); end
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 8'd0, 1'b1);
    n_vec++; if (spike_packet !== {12'd5, 8'd11}) begin n_err++; $display("FAIL ovf_second got %h exp %h", spike_packet, {12'd5, 8'd11}); end
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 8'd0, 1'b1);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained got %b exp 0", spike_valid); end
    n_vec++; if (spike_dropped !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", spike_dropped); end
  endtask

  task automatic test_back_to_back();
    do_clear(12'd5);
    spike_ready = 1'b0;
    load_cfg(32'h0, 32'h0, 4'd0);
    fire_at(32'h3F80_0000, 8'd30, 1'b0);
    fire_at(32'h3F80_0000, 8'd31, 1'b0);
    // Full buffer, pop and fire together: the pop makes room.
    fire_at(32'h3F80_0000, 8'd32, 1'b1);
    n_vec++; if (spike_dropped !== 1'b0) begin n_err++; $display("FAIL b2b_no_drop got %b exp 0", spike_dropped); end
    n_vec++; if (spike_packet !== {12'd5, 8'd31}) begin n_err++; $display("FAIL b2b_head got %h exp %h", spike_packet, {12'd5, 8'd31}); end
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0, 8'd0, 1'b1);
    n_vec++; if (spike_packet !== {12'd5, 8'd32}) begin n_err++; $display("FAIL b2b_tail got %h exp %h", spike_packet, {12'd5, 8'd32}); end
  endtask

  task automatic test_refractory();
    bit exp_fire;
    do_clear(12'd5);
    spike_ready = 1'b1;
    load_cfg(32'h0, 32'h3F00_0000, 4'd2);
    for (int ts = 0; ts < 9; ts++) begin
      fire_at(32'h3F80_0000, 8'(ts), 1'b1);
`ifdef SPIKE_GEN_REFRACTORY_EN
      exp_fire = (ts % 3 == 0);
`else
      exp_fire = 1'b1;
`endif
      n_vec++; if (spike_valid !== exp_fire) begin n_err++; $display("FAIL refr_fire_ts%0d got %b exp %b", ts, spike_valid, exp_fire); end
      n_vec++; if (potential_out !== 32'h3F00_0000) begin n_err++; $display("FAIL refr_pout_ts%0d got %h exp %h", ts, potential_out, 32'h3F00_0000); end
      if (exp_fire) begin
        n_vec++; if (spike_packet !== {12'd5, 8'(ts)}) begin n_err++; $display("FAIL refr_pkt_ts%0d got %h exp %h", ts, spike_packet, {12'd5, 8'(ts)}); end
      end
    end
  endtask

  task automatic test_clear_mid();
    do_clear(12'd5);
    spike_ready = 1'b0;
    load_cfg(32'h0, 32'h0, 4'd0);
    fire_at(32'h3F80_0000, 8'd40, 1'b0);
    fire_at(32'h3F80_0000, 8'd41, 1'b0);
    fire_at(32'h3F80_0000, 8'd42, 1'b0);
    do_clear(12'd9);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got %b exp 0", spike_valid); end
    n_vec++; if (spike_dropped !== 1'b0) begin n_err++; $display("FAIL clr_dropped got %b exp 0", spike_dropped); end
    fire_at(32'h7F00_0000, 8'd20, 1'b0);
    n_vec++; if (spike_valid !== 1'b0) begin n_err++; $display("FAIL clr_inf_thr got %b exp 0", spike_valid); end
    n_vec++; if (potential_out !== 32'h7F00_0000) begin n_err++; $display("FAIL clr_pout got %h exp %h", potential_out, 32'h7F00_0000); end
    load_cfg(32'h0, 32'h0, 4'd0);
    fire_at(32'h3F80_0000, 8'd21, 1'b0);
    n_vec++; if (spike_packet !== {12'd9, 8'd21}) begin n_err++; $display("FAIL clr_new_addr got %h exp %h", spike_packet, {12'd9, 8'd21}); end
  endtask

  logic [31:0] pool [12] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                             32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001,
                             32'h8000_0001, 32'h007F_FFFF, 32'h4120_0000, 32'hC120_0000};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 11)];
    return $urandom();
  endfunction

  task automatic test_random();
    logic we;
    do_clear(12'($urandom_range(0, 4095)));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_clear(12'($urandom_range(0, 4095)));
      we = ($urandom_range(0, 7) == 0);
      drive(we, pick(), pick(), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            pick(), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      n_vec++; if (potential_out_valid !== m_pv) begin n_err++; $display("FAIL rnd%0d_pout_valid got %b exp %b", i, potential_out_valid, m_pv); end
      n_vec++; if (potential_out !== m_pout) begin n_err++; $display("FAIL rnd%0d_pout got %h exp %h", i, potential_out, m_pout); end
      n_vec++; if (spike_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd%0d_spike_valid got %b exp %b", i, spike_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_vec++; if (spike_packet !== exp_q[0]) begin n_err++; $display("FAIL rnd%0d_packet got %h exp %h", i, spike_packet, exp_q[0]); end
      end
      n_vec++; if (spike_dropped !== m_dropped) begin n_err++; $display("FAIL rnd%0d_dropped got %b exp %b", i, spike_dropped, m_dropped); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_n                       = 1'b0;
    neuron_address_initialization = '0;
    cfg_we                        = 1'b0;
    cfg_threshold                 = '0;
    cfg_v_reset                   = '0;
    cfg_ref_period                = '0;
    timestep                      = '0;
    potential_valid               = 1'b0;
    potential_in                  = '0;
    spike_ready                   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_fire_basic();
    test_compare_edges();
    test_overflow();
    test_back_to_back();
    test_refractory();
    test_clear_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
